fetch_seq: RTL
==============

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter RESET_VECTOR, default 0, SHALL set the first fetch address after reset.
REQ-002 Parameter TRAP_VECTOR, default 16, SHALL set the trap target address; it exists only with FETCH_TRAP_EN.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 imem_req  output  1  SHALL signal a fetch request to instruction memory.
REQ-006 imem_addr  output  `WORDSIZE  SHALL carry the address of the outstanding fetch.
REQ-007 imem_ack  input  1  SHALL signal that instruction data for imem_addr is returned this cycle.
REQ-008 stall  input  1  SHALL indicate that decode cannot accept an instruction.
REQ-009 br_taken  input  1  SHALL be a one-cycle redirect request.
REQ-010 br_base, br_offset  input  `WORDSIZE each  SHALL be the branch base and offset.
REQ-011 inst_valid  output  1  SHALL mark a delivered instruction.
REQ-012 pc_out  output  `WORDSIZE  SHALL carry the PC of the delivered instruction.
REQ-013 trap  input  1  SHALL be a one-cycle trap request; it exists only with FETCH_TRAP_EN.

Function
REQ-014 The FSM SHALL have the states RST, REQ and HOLD, plus a 1-bit kill flag and a `WORDSIZE pc register.
REQ-015 RST SHALL move to REQ on the first cycle with reset low, with pc=RESET_VECTOR.
REQ-016 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until imem_ack.
REQ-017 On imem_ack in REQ with kill=0: inst_valid=1 and pc_out=pc in the same cycle.
REQ-018 In that case, if stall=0, the next state SHALL be REQ with pc<=pc+1.
REQ-019 In that case, if stall=1, the next state SHALL be HOLD with pc unchanged.
REQ-020 In HOLD, inst_valid and pc_out SHALL be held and imem_req SHALL be 0.
REQ-021 HOLD SHALL exit to REQ with pc<=pc+1 on the first cycle with stall=0.
REQ-022 The branch target SHALL be br_base+br_offset, truncated to `WORDSIZE; wrap-around SHALL be silent.
REQ-023 The pc increment SHALL likewise wrap from all-ones to 0.
REQ-024 br_taken in any non-RST state SHALL set pc<=target and SHALL move HOLD to REQ.
REQ-025 br_taken while a request is outstanding without ack SHALL also set kill=1.
REQ-026 imem_ack with kill=1 SHALL produce inst_valid=0, clear kill, and issue a request to pc (the target) next cycle.
REQ-027 br_taken coincident with imem_ack SHALL suppress inst_valid for that ack and SHALL NOT set kill.
REQ-028 Priority SHALL be reset > trap > br_taken > stall > sequential advance.
REQ-029 Minimum throughput SHALL be one instruction per cycle when imem_ack is 1 in consecutive cycles.
REQ-030 First-request latency SHALL be 1 cycle after reset deasserts.

Reset
REQ-031 While reset is high: state=RST, pc=RESET_VECTOR, kill=0.
REQ-032 While reset is high, imem_req=0, inst_valid=0, pc_out=0 and imem_addr=0.
REQ-033 Reset asserted mid-request SHALL abandon the request; a late imem_ack SHALL be ignored.

Configuration
REQ-034 Macro FETCH_TRAP_EN defined: the trap port SHALL exist and SHALL behave as br_taken, with target TRAP_VECTOR and higher priority than br_taken.
REQ-035 Macro FETCH_TRAP_EN undefined: the trap port and TRAP_VECTOR SHALL be absent, with no trap logic.

Structure
REQ-036 The shared package/defs SHALL hold `WORDSIZE, the state encodings (RST, REQ, HOLD) and the default vectors.
REQ-037 One sub-module, fetch_npc, SHALL be the combinational next-PC mux (pc+1, branch target, trap vector, hold); the FSM stays in fetch_seq.

Verification
REQ-038 Scenario: RESET_VECTOR=8, deassert reset, ack every cycle -> imem_addr 8,9,10,11; inst_valid=1 each cycle from the first ack.
REQ-039 Scenario: stall=1 for 3 cycles after the ack of pc=5 -> pc_out=5 held for 3 cycles, imem_req=0; the next request is to 6.
REQ-040 Scenario: br_taken with base=0x20, offset=4 while fetch 0x10 is unacked -> the ack of 0x10 gives inst_valid=0; the next imem_addr is 0x24.
REQ-041 Scenario: br_taken with base=all-ones, offset=2 -> next imem_addr=1; with pc=all-ones and no branch, the next address is 0.
REQ-042 Scenario: reset asserted while imem_req=1, then a late ack -> inst_valid stays 0; after release, the first imem_addr is RESET_VECTOR.
REQ-043 Scenario (FETCH_TRAP_EN): trap and br_taken in the same cycle -> next imem_addr=TRAP_VECTOR=16.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: word size, FSM state encodings,
// next-PC select codes and default reset/trap vectors.
`ifndef WORDSIZE
`define WORDSIZE 32
`endif

package fetch_seq_pkg;
    localparam int WORD_W = `WORDSIZE;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_VECTOR = WORD_W'(32'd0);
    localparam logic [WORD_W-1:0] DEFAULT_TRAP_VECTOR  = WORD_W'(32'd16);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NPC_HOLD = 2'd0,
        NPC_INC  = 2'd1,
        NPC_BR   = 2'd2,
        NPC_TRAP = 2'd3
    } npc_sel_t;
endpackage

// File: rtl/fetch_npc.sv
// Combinational next-PC mux: hold, pc+1, branch target, or trap vector
// (the trap input of the mux is only populated when FETCH_TRAP_EN is defined).
module fetch_npc
    import fetch_seq_pkg::*;
`ifdef FETCH_TRAP_EN
    #(parameter logic [WORD_W-1:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR)
`endif
(
    input  logic [WORD_W-1:0] pc,
    input  npc_sel_t          sel,
    input  logic [WORD_W-1:0] br_base,
    input  logic [WORD_W-1:0] br_offset,
    output logic [WORD_W-1:0] npc
);
    // Increment and branch add both wrap silently at the word boundary.
    always_comb begin
        npc = pc;
        case (sel)
            NPC_HOLD: npc = pc;
            NPC_INC:  npc = pc + WORD_W'(32'd1);
            NPC_BR:   npc = br_base + br_offset;
`ifdef FETCH_TRAP_EN
            NPC_TRAP: npc = TRAP_VECTOR;
`else
            NPC_TRAP: npc = pc;
`endif
            default:  npc = pc;
        endcase
    end
endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer (RST/REQ/HOLD FSM) with branch redirect and kill
// of an in-flight fetch; optional trap redirect enabled by FETCH_TRAP_EN.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
`ifdef FETCH_TRAP_EN
    ,
    parameter logic [WORD_W-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
`endif
) (
    input  logic              CLK,
    input  logic              reset,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [WORD_W-1:0] br_base,
    input  logic [WORD_W-1:0] br_offset,
`ifdef FETCH_TRAP_EN
    input  logic              trap,
`endif
    output logic              inst_valid,
    output logic [WORD_W-1:0] pc_out
);
    state_t            state_r, state_d;
    logic              kill_r, kill_d;
    logic [WORD_W-1:0] pc_r;
    logic [WORD_W-1:0] addr_r;
    logic [WORD_W-1:0] npc;
    npc_sel_t          sel;
    npc_sel_t          redirect_sel;
    logic              redirect;
    logic              load_addr;

    fetch_npc
`ifdef FETCH_TRAP_EN
        #(.TRAP_VECTOR(TRAP_VECTOR))
`endif
    u_npc (
        .pc        (pc_r),
        .sel       (sel),
        .br_base   (br_base),
        .br_offset (br_offset),
        .npc       (npc)
    );

    // Trap outranks branch; both are treated as a single redirect request.
    always_comb begin
        redirect     = br_taken;
        redirect_sel = NPC_BR;
`ifdef FETCH_TRAP_EN
        if (trap) begin
            redirect     = 1'b1;
            redirect_sel = NPC_TRAP;
        end else begin
            redirect_sel = NPC_BR;
        end
`endif
    end

    // Next-state logic; addr_r only reloads when no fetch is left outstanding.
    always_comb begin
        state_d   = state_r;
        kill_d    = kill_r;
        sel       = NPC_HOLD;
        load_addr = 1'b0;
        case (state_r)
            ST_RST: begin
                state_d   = ST_REQ;
                load_addr = 1'b1;
            end
            ST_REQ: begin
                if (redirect) begin
                    sel       = redirect_sel;
                    kill_d    = ~imem_ack;
                    load_addr = imem_ack;
                end else if (imem_ack) begin
                    if (kill_r) begin
                        kill_d    = 1'b0;
                        load_addr = 1'b1;
                    end else if (stall) begin
                        state_d = ST_HOLD;
                    end else begin
                        sel       = NPC_INC;
                        load_addr = 1'b1;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    sel       = redirect_sel;
                    state_d   = ST_REQ;
                    load_addr = 1'b1;
                end else if (stall) begin
                    state_d = ST_HOLD;
                end else begin
                    sel       = NPC_INC;
                    state_d   = ST_REQ;
                    load_addr = 1'b1;
                end
            end
            default: begin
                state_d = ST_RST;
                kill_d  = 1'b0;
            end
        endcase
    end

    // State, pc, kill flag and outstanding-fetch address registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r <= ST_RST;
            pc_r    <= RESET_VECTOR;
            addr_r  <= RESET_VECTOR;
            kill_r  <= 1'b0;
        end else begin
            state_r <= state_d;
            pc_r    <= npc;
            kill_r  <= kill_d;
            if (load_addr) begin
                addr_r <= npc;
            end
        end
    end

    // Outputs are forced quiet while reset is high, even before the first edge.
    always_comb begin
        imem_req   = ~reset && (state_r == ST_REQ);
        imem_addr  = imem_req ? addr_r : WORD_W'(32'd0);
        inst_valid = (imem_req && imem_ack && ~kill_r && ~redirect)
                   || (~reset && (state_r == ST_HOLD));
        pc_out     = inst_valid ? pc_r : WORD_W'(32'd0);
    end
endmodule
